// File: rtl/k10_dbus_arbiter.sv
// k10_dbus_arbiter: shares the single K10 memory port between instruction
// fetch (IBUS) and the load/store unit (DBUS) on the req/gnt/rvalid protocol.
// At most one transaction is outstanding; each response is steered back to
// the master that issued it.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_ibus_* / o_ibus_*   fetch master: req/addr in; gnt/rvalid/rdata/err out
//   i_dbus_* / o_dbus_*   LSU master: req/we/addr/wdata/wstrb in; gnt/rvalid/rdata/err out
//   o_mem_* / i_mem_*     slave port: req/we/addr/wdata/wstrb out; gnt/rvalid/rdata/err in
//
// Parameters:
//   STARVE_LIMIT  cycles IBUS may wait with req high before it is forced first (1..255)
//   DATA_FIRST    1 = DBUS wins ties by default, 0 = IBUS wins ties
module k10_dbus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter bit          DATA_FIRST   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ibus_req,
  input  logic [31:0] i_ibus_addr,
  output logic        o_ibus_gnt,
  output logic        o_ibus_rvalid,
  output logic [31:0] o_ibus_rdata,
  output logic        o_ibus_err,
  input  logic        i_dbus_req,
  input  logic        i_dbus_we,
  input  logic [31:0] i_dbus_addr,
  input  logic [31:0] i_dbus_wdata,
  input  logic [3:0]  i_dbus_wstrb,
  output logic        o_dbus_gnt,
  output logic        o_dbus_rvalid,
  output logic [31:0] o_dbus_rdata,
  output logic        o_dbus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic        i_mem_err,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic       {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IBUS, OWN_DBUS} owner_t;

  state_t           r_state;
  owner_t           r_owner;
  logic             r_lock;
  owner_t           r_lock_sel;
  logic [CNT_W-1:0] r_starve_cnt;

  logic   w_window;
  logic   w_starved;
  owner_t w_sel;
  logic   w_req;
  logic   w_gnt;
  logic   w_rsp;

  // A new request may issue when idle, or in the cycle the outstanding one completes.
  assign w_window  = !i_rst && ((r_state == S_IDLE) || i_mem_rvalid);
  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Master selection; a stalled request keeps its slot until the slave accepts it.
  always_comb begin
    w_sel = OWN_NONE;
    if (r_lock) begin
      w_sel = r_lock_sel;
    end else if (i_ibus_req && i_dbus_req) begin
      if (w_starved || !DATA_FIRST) w_sel = OWN_IBUS;
      else                          w_sel = OWN_DBUS;
    end else if (i_ibus_req) begin
      w_sel = OWN_IBUS;
    end else if (i_dbus_req) begin
      w_sel = OWN_DBUS;
    end
  end

  assign w_req = w_window && (w_sel != OWN_NONE);
  assign w_gnt = w_req && i_mem_gnt;
  // Responses only count while a transaction is outstanding; stale ones are dropped.
  assign w_rsp = !i_rst && (r_state == S_BUSY) && i_mem_rvalid;

  // Slave request payload mux; fetches are always full-word reads.
  always_comb begin
    o_mem_req   = w_req;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_mem_wstrb = 4'h0;
    if (w_req && (w_sel == OWN_DBUS)) begin
      o_mem_we    = i_dbus_we;
      o_mem_addr  = i_dbus_addr;
      o_mem_wdata = i_dbus_wdata;
      o_mem_wstrb = i_dbus_wstrb;
    end else if (w_req && (w_sel == OWN_IBUS)) begin
      o_mem_addr  = i_ibus_addr;
    end
  end

  assign o_ibus_gnt = w_gnt && (w_sel == OWN_IBUS);
  assign o_dbus_gnt = w_gnt && (w_sel == OWN_DBUS);

  // Response steering to the registered owner.
  assign o_ibus_rvalid = w_rsp && (r_owner == OWN_IBUS);
  assign o_dbus_rvalid = w_rsp && (r_owner == OWN_DBUS);
  assign o_ibus_rdata  = o_ibus_rvalid ? i_mem_rdata : 32'h0;
  assign o_dbus_rdata  = o_dbus_rvalid ? i_mem_rdata : 32'h0;
  assign o_ibus_err    = o_ibus_rvalid && i_mem_err;
  assign o_dbus_err    = o_dbus_rvalid && i_mem_err;

  // Outstanding-transaction FSM, request lock and fetch starvation counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_NONE;
      r_lock       <= 1'b0;
      r_lock_sel   <= OWN_NONE;
      r_starve_cnt <= '0;
    end else begin
      if (w_gnt) begin
        r_state <= S_BUSY;
        r_owner <= w_sel;
      end else if (w_rsp) begin
        r_state <= S_IDLE;
        r_owner <= OWN_NONE;
      end

      if (w_gnt) begin
        r_lock <= 1'b0;
      end else if (w_req) begin
        r_lock     <= 1'b1;
        r_lock_sel <= w_sel;
      end

      if (o_ibus_gnt) begin
        r_starve_cnt <= '0;
      end else if (i_ibus_req && (r_starve_cnt < CNT_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_k10_dbus_arbiter.sv
// Bench for k10_dbus_arbiter (STARVE_LIMIT=3, DATA_FIRST=1): table of single
// transactions plus hand sequences for back-to-back, starvation, lock,
// error/spurious response and reset mid-transaction. Responses are checked
// through an expected-response queue.
module tb_k10_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  logic        o_ibus_gnt, o_ibus_rvalid, o_ibus_err;
  logic [31:0] o_ibus_rdata;
  logic        o_dbus_gnt, o_dbus_rvalid, o_dbus_err;
  logic [31:0] o_dbus_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb_q[$];

  typedef struct {
    string       name;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwstrb;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        e_ignt;
    logic        e_dgnt;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  k10_dbus_arbiter #(.STARVE_LIMIT(3), .DATA_FIRST(1'b1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ibus_req(ibus_req), .i_ibus_addr(ibus_addr),
    .o_ibus_gnt(o_ibus_gnt), .o_ibus_rvalid(o_ibus_rvalid),
    .o_ibus_rdata(o_ibus_rdata), .o_ibus_err(o_ibus_err),
    .i_dbus_req(dbus_req), .i_dbus_we(dbus_we), .i_dbus_addr(dbus_addr),
    .i_dbus_wdata(dbus_wdata), .i_dbus_wstrb(dbus_wstrb),
    .o_dbus_gnt(o_dbus_gnt), .o_dbus_rvalid(o_dbus_rvalid),
    .o_dbus_rdata(o_dbus_rdata), .o_dbus_err(o_dbus_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_err(mem_err),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops the expected response whenever one is due and compares routing.
  task automatic monitor();
    rsp_t e;
    if (o_ibus_rvalid || o_dbus_rvalid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got ibus=%b dbus=%b expected none", o_ibus_rvalid, o_dbus_rvalid);
      end else begin
        e = sb_q.pop_front();
        chk1("rsp_ibus_rvalid", o_ibus_rvalid, !e.is_d);
        chk1("rsp_dbus_rvalid", o_dbus_rvalid, e.is_d);
        chk32("rsp_ibus_rdata", o_ibus_rdata, e.is_d ? 32'h0 : e.rdata);
        chk32("rsp_dbus_rdata", o_dbus_rdata, e.is_d ? e.rdata : 32'h0);
        chk1("rsp_ibus_err", o_ibus_err, !e.is_d && e.err);
        chk1("rsp_dbus_err", o_dbus_err, e.is_d && e.err);
      end
    end else if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_rvalid: got none expected %0d pending", sb_q.size());
      void'(sb_q.pop_front());
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rsp(input logic is_d, input logic [31:0] rdata, input logic err);
    rsp_t e;
    e.is_d = is_d; e.rdata = rdata; e.err = err;
    sb_q.push_back(e);
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
  endtask

  task automatic clr_rsp();
    mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_mem_req"}, o_mem_req, 1'b0);
    chk32({tag, "_mem_addr"}, o_mem_addr, 32'h0);
    chk1({tag, "_ibus_gnt"}, o_ibus_gnt, 1'b0);
    chk1({tag, "_dbus_gnt"}, o_dbus_gnt, 1'b0);
    chk1({tag, "_ibus_rvalid"}, o_ibus_rvalid, 1'b0);
    chk1({tag, "_dbus_rvalid"}, o_dbus_rvalid, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"dstore",   1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 2,
                32'h0, 1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF};
    vecs[1] = '{"fetch",    1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1,
                32'h0000_0013, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 32'h0, 4'h0};
    vecs[2] = '{"dload",    1'b0, 32'h0, 1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'h0, 3,
                32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 32'h2000_0010, 1'b0, 32'h0, 4'h0};
    vecs[3] = '{"dstoreb",  1'b0, 32'h0, 1'b1, 1'b1, 32'h3000_0003, 32'h0000_00AB, 4'h8, 1,
                32'h0, 1'b0, 1'b0, 1'b1, 32'h3000_0003, 1'b1, 32'h0000_00AB, 4'h8};
    vecs[4] = '{"none",     1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0,
                32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    vecs[5] = '{"fetcherr", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1,
                32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 4'h0};

    rst = 1'b1;
    ibus_req = 1'b0; ibus_addr = 32'h0;
    dbus_req = 1'b0; dbus_we = 1'b0; dbus_addr = 32'h0; dbus_wdata = 32'h0; dbus_wstrb = 4'h0;
    mem_gnt = 1'b0;
    clr_rsp();

    // Reset state
    sample();
    chk_all_zero("reset");
    adv();
    adv();
    rst = 1'b0;
    sample();
    chk_all_zero("post_reset");
    adv();

    // Single transactions from IDLE
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = vecs[i];
      ibus_req = v.ireq; ibus_addr = v.iaddr;
      dbus_req = v.dreq; dbus_we = v.dwe; dbus_addr = v.daddr;
      dbus_wdata = v.dwdata; dbus_wstrb = v.dwstrb;
      mem_gnt = 1'b1;
      sample();
      chk1({v.name, "_mem_req"}, o_mem_req, v.ireq | v.dreq);
      chk1({v.name, "_ibus_gnt"}, o_ibus_gnt, v.e_ignt);
      chk1({v.name, "_dbus_gnt"}, o_dbus_gnt, v.e_dgnt);
      chk32({v.name, "_mem_addr"}, o_mem_addr, v.e_addr);
      chk1({v.name, "_mem_we"}, o_mem_we, v.e_we);
      chk32({v.name, "_mem_wdata"}, o_mem_wdata, v.e_wdata);
      chk32({v.name, "_mem_wstrb"}, 32'(o_mem_wstrb), 32'(v.e_wstrb));
      adv();
      ibus_req = 1'b0; dbus_req = 1'b0;
      if (v.ireq || v.dreq) begin
        for (int k = 1; k < v.lat; k++) begin
          sample();
          chk1({v.name, "_gap_mem_req"}, o_mem_req, 1'b0);
          adv();
        end
        push_rsp(v.dreq, v.rdata, v.err);
        sample();
        adv();
        clr_rsp();
      end
    end

    // Simultaneous requests: DBUS first, IBUS issued in DBUS response cycle
    ibus_req = 1'b1; ibus_addr = 32'h0000_0100;
    dbus_req = 1'b1; dbus_we = 1'b0; dbus_addr = 32'h2000_0000; dbus_wdata = 32'h0; dbus_wstrb = 4'h0;
    mem_gnt = 1'b1;
    sample();
    chk1("sim_c0_dbus_gnt", o_dbus_gnt, 1'b1);
    chk1("sim_c0_ibus_gnt", o_ibus_gnt, 1'b0);
    chk32("sim_c0_mem_addr", o_mem_addr, 32'h2000_0000);
    adv();
    dbus_req = 1'b0;
    sample();
    chk1("sim_c1_busy_mem_req", o_mem_req, 1'b0);
    chk1("sim_c1_busy_ibus_gnt", o_ibus_gnt, 1'b0);
    adv();
    push_rsp(1'b1, 32'h55AA_55AA, 1'b0);
    sample();
    chk1("sim_c2_ibus_gnt", o_ibus_gnt, 1'b1);
    chk32("sim_c2_mem_addr", o_mem_addr, 32'h0000_0100);
    adv();
    ibus_req = 1'b0;
    push_rsp(1'b0, 32'h0000_0013, 1'b0);
    sample();
    chk1("sim_c3_ibus_rvalid", o_ibus_rvalid, 1'b1);
    chk1("sim_c3_dbus_rvalid", o_dbus_rvalid, 1'b0);
    adv();
    clr_rsp();

    // Starvation: IBUS forced after 3 waiting cycles, counter restarts after grant
    ibus_req = 1'b1; ibus_addr = 32'h0000_0300;
    dbus_req = 1'b1; dbus_we = 1'b1; dbus_addr = 32'h4000_0000; dbus_wdata = 32'h1; dbus_wstrb = 4'hF;
    mem_gnt = 1'b1;
    for (int t = 0; t < 8; t++) begin
      logic exp_i;
      exp_i = (t == 3) || (t == 7);
      if (t > 0) push_rsp(!((t - 1) == 3), 32'h100 + 32'(t), 1'b0);
      sample();
      chk1($sformatf("starve_t%0d_ibus_gnt", t), o_ibus_gnt, exp_i);
      chk1($sformatf("starve_t%0d_dbus_gnt", t), o_dbus_gnt, !exp_i);
      adv();
      if (t == 3) ibus_addr = 32'h0000_0304;
    end
    ibus_req = 1'b0; dbus_req = 1'b0;
    push_rsp(1'b0, 32'h0000_0777, 1'b0);
    sample();
    chk1("starve_end_mem_req", o_mem_req, 1'b0);
    adv();
    clr_rsp();

    // Lock: stalled IBUS keeps the port until the slave grants
    mem_gnt = 1'b0;
    ibus_req = 1'b1; ibus_addr = 32'h0000_0500;
    dbus_we = 1'b1; dbus_addr = 32'h6000_0008; dbus_wdata = 32'h0000_0011; dbus_wstrb = 4'h3;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) dbus_req = 1'b1;
      sample();
      chk1($sformatf("lock_c%0d_mem_req", c), o_mem_req, 1'b1);
      chk32($sformatf("lock_c%0d_mem_addr", c), o_mem_addr, 32'h0000_0500);
      chk1($sformatf("lock_c%0d_dbus_gnt", c), o_dbus_gnt, 1'b0);
      adv();
    end
    mem_gnt = 1'b1;
    sample();
    chk1("lock_gnt_ibus", o_ibus_gnt, 1'b1);
    chk1("lock_gnt_dbus", o_dbus_gnt, 1'b0);
    chk32("lock_gnt_addr", o_mem_addr, 32'h0000_0500);
    adv();
    ibus_req = 1'b0;
    push_rsp(1'b0, 32'h0000_5005, 1'b0);
    sample();
    chk1("lock_next_dbus_gnt", o_dbus_gnt, 1'b1);
    chk32("lock_next_addr", o_mem_addr, 32'h6000_0008);
    chk1("lock_next_we", o_mem_we, 1'b1);
    chk32("lock_next_wdata", o_mem_wdata, 32'h0000_0011);
    chk32("lock_next_wstrb", 32'(o_mem_wstrb), 32'h3);
    adv();
    dbus_req = 1'b0;
    push_rsp(1'b1, 32'h0, 1'b0);
    sample();
    adv();
    clr_rsp();

    // Error response, then spurious response in IDLE
    dbus_req = 1'b1; dbus_we = 1'b0; dbus_addr = 32'h7000_0000; dbus_wdata = 32'h0; dbus_wstrb = 4'h0;
    sample();
    chk1("err_dbus_gnt", o_dbus_gnt, 1'b1);
    adv();
    dbus_req = 1'b0;
    push_rsp(1'b1, 32'hBAD0_0000, 1'b1);
    sample();
    chk1("err_dbus_err", o_dbus_err, 1'b1);
    adv();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_err = 1'b1;
    sample();
    chk1("spur_ibus_rvalid", o_ibus_rvalid, 1'b0);
    chk1("spur_dbus_rvalid", o_dbus_rvalid, 1'b0);
    chk1("spur_dbus_err", o_dbus_err, 1'b0);
    chk32("spur_dbus_rdata", o_dbus_rdata, 32'h0);
    adv();
    clr_rsp();

    // Async reset while BUSY; stale response ignored afterwards
    dbus_req = 1'b1; dbus_we = 1'b1; dbus_addr = 32'h8000_0000; dbus_wdata = 32'h77; dbus_wstrb = 4'hF;
    sample();
    chk1("rst_pre_dbus_gnt", o_dbus_gnt, 1'b1);
    adv();
    dbus_req = 1'b0;
    rst = 1'b1;
    ibus_req = 1'b1; ibus_addr = 32'h0000_0900; dbus_req = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    sample();
    chk_all_zero("in_reset");
    adv();
    rst = 1'b0;
    ibus_req = 1'b0; dbus_req = 1'b0;
    sample();
    chk_all_zero("stale");
    adv();
    clr_rsp();
    dbus_req = 1'b1; dbus_we = 1'b0; dbus_addr = 32'h9000_0000;
    sample();
    chk1("after_rst_dbus_gnt", o_dbus_gnt, 1'b1);
    chk32("after_rst_addr", o_mem_addr, 32'h9000_0000);
    adv();
    dbus_req = 1'b0;
    push_rsp(1'b1, 32'h0000_600D, 1'b0);
    sample();
    adv();
    clr_rsp();

    chk32("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
